// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer.
// Provides entry-index width, the null entry tag, instruction-type encoding,
// the per-entry payload struct and small type-classification helpers.
package rob_pkg;

  localparam int unsigned ROB_ENTRY_W = 6;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned REG_W       = 5;

  // Tag meaning "no entry"; lies outside every legal index for sizes up to 32.
  localparam logic [ROB_ENTRY_W-1:0] ENTRY_NULL = 6'b100000;

  typedef enum logic [1:0] {
    ROB_T_REG    = 2'd0,
    ROB_T_BRANCH = 2'd1,
    ROB_T_STORE  = 2'd2,
    ROB_T_JUMP   = 2'd3
  } rob_type_e;

  // Per-entry payload; the valid bit is kept separately so it alone needs reset.
  typedef struct packed {
    logic             ready;
    rob_type_e        typ;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  value;
    logic [XLEN-1:0]  pred_pc;
    logic [XLEN-1:0]  actual_pc;
  } rob_entry_t;

  // Types whose target is checked against the prediction at commit.
  function automatic logic is_ctrl(input rob_type_e t);
    return (t == ROB_T_BRANCH) || (t == ROB_T_JUMP);
  endfunction

  // Types that write a destination register.
  function automatic logic writes_rd(input rob_type_e t);
    return (t == ROB_T_REG) || (t == ROB_T_JUMP);
  endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: allocates entries in program order, collects ALU/LSB
// writebacks, retires one entry per cycle and flags mispredictions at commit.
// Ports:
//   clk, rst (sync, active-high), rdy (low freezes state)
//   issue_*          : allocation request; issue_entry is the slot it receives
//   rob_full         : combinational, count == ROB_SIZE
//   qj_/qk_*         : combinational operand lookups with same-cycle bus forwarding
//   alu_*, lsb_*     : result writeback buses
//   rob_commit..commit_store : registered retire bus
//   rollback, rollback_pc    : registered misprediction pulse and redirect PC
module rob
  import rob_pkg::*;
#(
  parameter int unsigned ROB_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   issue_valid,
  input  logic [1:0]             issue_type,
  input  logic [REG_W-1:0]       issue_rd,
  input  logic [XLEN-1:0]        issue_pred_pc,
  output logic [ROB_ENTRY_W-1:0] issue_entry,
  output logic                   rob_full,
  input  logic [ROB_ENTRY_W-1:0] qj_entry,
  input  logic [ROB_ENTRY_W-1:0] qk_entry,
  output logic                   qj_ready,
  output logic                   qk_ready,
  output logic [XLEN-1:0]        qj_value,
  output logic [XLEN-1:0]        qk_value,
  input  logic                   alu_broadcast,
  input  logic [ROB_ENTRY_W-1:0] alu_entry,
  input  logic [XLEN-1:0]        alu_result,
  input  logic [XLEN-1:0]        alu_pc_out,
  input  logic                   lsb_broadcast,
  input  logic [ROB_ENTRY_W-1:0] lsb_entry,
  input  logic [XLEN-1:0]        lsb_result,
  output logic                   rob_commit,
  output logic [ROB_ENTRY_W-1:0] rob_entry,
  output logic [XLEN-1:0]        rob_result,
  output logic [REG_W-1:0]       commit_rd,
  output logic                   commit_store,
  output logic                   rollback,
  output logic [XLEN-1:0]        rollback_pc
);

  localparam int unsigned IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;

  function automatic logic in_range(input logic [ROB_ENTRY_W-1:0] e);
    return e < ROB_ENTRY_W'(ROB_SIZE);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ROB_ENTRY_W-1:0] e);
    return IDX_W'(e);
  endfunction

  // Explicit wrap so non-power-of-two index widths never overrun.
  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(ROB_SIZE - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  // Storage and pointers
  logic [ROB_SIZE-1:0]    valid_q, valid_d;
  rob_entry_t             ent_q [ROB_SIZE];
  rob_entry_t             ent_d [ROB_SIZE];
  logic [IDX_W-1:0]       head_q, head_d;
  logic [IDX_W-1:0]       tail_q, tail_d;
  logic [ROB_ENTRY_W-1:0] count_q, count_d;

  // Registered commit / rollback outputs
  logic                   commit_q, commit_d;
  logic [ROB_ENTRY_W-1:0] rob_entry_q, rob_entry_d;
  logic [XLEN-1:0]        result_q, result_d;
  logic [REG_W-1:0]       commit_rd_q, commit_rd_d;
  logic                   store_q, store_d;
  logic                   rollback_q, rollback_d;
  logic [XLEN-1:0]        rollback_pc_q, rollback_pc_d;

  rob_entry_t head_ent;
  logic       do_commit;
  logic       mispredict;
  logic       do_issue;
  logic       alu_hit;
  logic       lsb_hit;

  assign head_ent    = ent_q[head_q];
  assign rob_full    = (count_q == ROB_ENTRY_W'(ROB_SIZE));
  assign issue_entry = ROB_ENTRY_W'(tail_q);

  assign do_commit  = valid_q[head_q] && head_ent.ready;
  assign mispredict = do_commit && is_ctrl(head_ent.typ) &&
                      (head_ent.actual_pc != head_ent.pred_pc);
  // Issue is dropped on the misprediction edge and during the following rollback cycle.
  assign do_issue   = issue_valid && !rob_full && !rollback_q && !mispredict;
  assign alu_hit    = alu_broadcast && in_range(alu_entry) && valid_q[to_idx(alu_entry)];
  assign lsb_hit    = lsb_broadcast && in_range(lsb_entry) && valid_q[to_idx(lsb_entry)];

  // Next-state: commit, writeback, issue, then misprediction flush
  always_comb begin
    valid_d       = valid_q;
    ent_d         = ent_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    commit_d      = 1'b0;
    rollback_d    = 1'b0;
    rob_entry_d   = rob_entry_q;
    result_d      = result_q;
    commit_rd_d   = commit_rd_q;
    store_d       = store_q;
    rollback_pc_d = rollback_pc_q;

    if (rdy) begin
      if (do_commit) begin
        commit_d    = 1'b1;
        rob_entry_d = ROB_ENTRY_W'(head_q);
        result_d    = head_ent.value;
        commit_rd_d = writes_rd(head_ent.typ) ? head_ent.rd : '0;
        store_d     = (head_ent.typ == ROB_T_STORE);
        if (mispredict) begin
          rollback_d    = 1'b1;
          rollback_pc_d = head_ent.actual_pc;
        end
      end

      // ALU applied last so it wins if both buses name the same entry.
      if (lsb_hit) begin
        ent_d[to_idx(lsb_entry)].ready = 1'b1;
        ent_d[to_idx(lsb_entry)].value = lsb_result;
      end
      if (alu_hit) begin
        ent_d[to_idx(alu_entry)].ready     = 1'b1;
        ent_d[to_idx(alu_entry)].value     = alu_result;
        ent_d[to_idx(alu_entry)].actual_pc = alu_pc_out;
      end

      if (do_commit) begin
        valid_d[head_q] = 1'b0;
        head_d          = ptr_inc(head_q);
      end

      if (do_issue) begin
        valid_d[tail_q] = 1'b1;
        ent_d[tail_q]   = '{ready:     1'b0,
                            typ:       rob_type_e'(issue_type),
                            rd:        issue_rd,
                            value:     '0,
                            pred_pc:   issue_pred_pc,
                            actual_pc: '0};
        tail_d          = ptr_inc(tail_q);
      end

      count_d = count_q + ROB_ENTRY_W'(do_issue) - ROB_ENTRY_W'(do_commit);

      if (mispredict) begin
        valid_d = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end
  end

  // Control state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_q      <= 1'b0;
      rob_entry_q   <= ENTRY_NULL;
      result_q      <= '0;
      commit_rd_q   <= '0;
      store_q       <= 1'b0;
      rollback_q    <= 1'b0;
      rollback_pc_q <= '0;
    end else begin
      valid_q       <= valid_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commit_q      <= commit_d;
      rob_entry_q   <= rob_entry_d;
      result_q      <= result_d;
      commit_rd_q   <= commit_rd_d;
      store_q       <= store_d;
      rollback_q    <= rollback_d;
      rollback_pc_q <= rollback_pc_d;
    end
  end

  // Entry payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  // Operand lookups with same-cycle forwarding, ALU before LSB
  logic [ROB_ENTRY_W-1:0] lk_entry [2];
  logic [1:0]             lk_ready;
  logic [XLEN-1:0]        lk_value [2];

  assign lk_entry[0] = qj_entry;
  assign lk_entry[1] = qk_entry;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_ready[p] = 1'b0;
      lk_value[p] = '0;
      if (in_range(lk_entry[p]) && valid_q[to_idx(lk_entry[p])]) begin
        if (alu_broadcast && (alu_entry == lk_entry[p])) begin
          lk_ready[p] = 1'b1;
          lk_value[p] = alu_result;
        end else if (lsb_broadcast && (lsb_entry == lk_entry[p])) begin
          lk_ready[p] = 1'b1;
          lk_value[p] = lsb_result;
        end else if (ent_q[to_idx(lk_entry[p])].ready) begin
          lk_ready[p] = 1'b1;
          lk_value[p] = ent_q[to_idx(lk_entry[p])].value;
        end
      end
    end
  end

  assign qj_ready = lk_ready[0];
  assign qk_ready = lk_ready[1];
  assign qj_value = lk_value[0];
  assign qk_value = lk_value[1];

  assign rob_commit   = commit_q;
  assign rob_entry    = rob_entry_q;
  assign rob_result   = result_q;
  assign commit_rd    = commit_rd_q;
  assign commit_store = store_q;
  assign rollback     = rollback_q;
  assign rollback_pc  = rollback_pc_q;

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed sequences, a lookup vector table and
// randomized traffic compared against a queue-based program-order model.
module tb_rob;
  import rob_pkg::*;

  localparam int SIZE = 32;

  logic        clk = 1'b0;
  logic        rst, rdy, issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pred_pc;
  logic [5:0]  issue_entry;
  logic        rob_full;
  logic [5:0]  qj_entry, qk_entry;
  logic        qj_ready, qk_ready;
  logic [31:0] qj_value, qk_value;
  logic        alu_broadcast;
  logic [5:0]  alu_entry;
  logic [31:0] alu_result, alu_pc_out;
  logic        lsb_broadcast;
  logic [5:0]  lsb_entry;
  logic [31:0] lsb_result;
  logic        rob_commit;
  logic [5:0]  rob_entry;
  logic [31:0] rob_result;
  logic [4:0]  commit_rd;
  logic        commit_store, rollback;
  logic [31:0] rollback_pc;

  always #5 clk = ~clk;

  rob #(.ROB_SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_pc(issue_pred_pc), .issue_entry(issue_entry), .rob_full(rob_full),
    .qj_entry(qj_entry), .qk_entry(qk_entry), .qj_ready(qj_ready), .qk_ready(qk_ready),
    .qj_value(qj_value), .qk_value(qk_value),
    .alu_broadcast(alu_broadcast), .alu_entry(alu_entry), .alu_result(alu_result),
    .alu_pc_out(alu_pc_out),
    .lsb_broadcast(lsb_broadcast), .lsb_entry(lsb_entry), .lsb_result(lsb_result),
    .rob_commit(rob_commit), .rob_entry(rob_entry), .rob_result(rob_result),
    .commit_rd(commit_rd), .commit_store(commit_store),
    .rollback(rollback), .rollback_pc(rollback_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: in-flight instructions in program order
  typedef struct {
    int          idx;
    int          typ;
    int          rd;
    logic [31:0] value;
    logic [31:0] pred;
    logic [31:0] actual;
    bit          ready;
  } ment_t;

  ment_t       mq[$];
  int          m_next;
  bit          e_commit, e_rollback, e_store;
  int          e_entry, e_rd;
  logic [31:0] e_result, e_rbpc;

  function automatic int find(input int idx);
    foreach (mq[i]) if (mq[i].idx == idx) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_next = 0;
    e_commit = 0; e_rollback = 0; e_store = 0;
    e_entry = 32; e_rd = 0; e_result = 0; e_rbpc = 0;
  endtask

  task automatic model_look(input logic [5:0] e, output bit r, output logic [31:0] v);
    int p;
    p = find(int'(e));
    r = 0; v = 0;
    if (p >= 0) begin
      if (alu_broadcast && alu_entry == e) begin r = 1; v = alu_result; end
      else if (lsb_broadcast && lsb_entry == e) begin r = 1; v = lsb_result; end
      else if (mq[p].ready) begin r = 1; v = mq[p].value; end
    end
  endtask

  task automatic model_step();
    bit rb_prev, mis, full, committed;
    int p;
    ment_t n;
    if (rst) begin model_reset(); return; end
    if (!rdy) begin e_commit = 0; e_rollback = 0; return; end
    rb_prev = e_rollback;
    full = (mq.size() == SIZE);
    mis = 0; committed = 0;
    e_commit = 0; e_rollback = 0;
    if (mq.size() > 0 && mq[0].ready) begin
      committed = 1;
      e_commit = 1;
      e_entry  = mq[0].idx;
      e_result = mq[0].value;
      e_rd     = (mq[0].typ == 0 || mq[0].typ == 3) ? mq[0].rd : 0;
      e_store  = (mq[0].typ == 2);
      if ((mq[0].typ == 1 || mq[0].typ == 3) && mq[0].actual != mq[0].pred) begin
        mis = 1; e_rollback = 1; e_rbpc = mq[0].actual;
      end
    end
    if (lsb_broadcast) begin
      p = find(int'(lsb_entry));
      if (p >= 0) begin mq[p].ready = 1; mq[p].value = lsb_result; end
    end
    if (alu_broadcast) begin
      p = find(int'(alu_entry));
      if (p >= 0) begin mq[p].ready = 1; mq[p].value = alu_result; mq[p].actual = alu_pc_out; end
    end
    if (committed) void'(mq.pop_front());
    if (mis) begin
      mq.delete();
      m_next = 0;
    end else if (issue_valid && !full && !rb_prev) begin
      n.idx = m_next; n.typ = int'(issue_type); n.rd = int'(issue_rd);
      n.value = 0; n.pred = issue_pred_pc; n.actual = 0; n.ready = 0;
      mq.push_back(n);
      m_next = (m_next + 1) % SIZE;
    end
  endtask

  task automatic check_comb();
    bit r; logic [31:0] v;
    chk("rob_full", 32'(rob_full), 32'(mq.size() == SIZE));
    chk("issue_entry", 32'(issue_entry), 32'(m_next));
    model_look(qj_entry, r, v);
    chk("qj_ready", 32'(qj_ready), 32'(r));
    chk("qj_value", qj_value, v);
    model_look(qk_entry, r, v);
    chk("qk_ready", 32'(qk_ready), 32'(r));
    chk("qk_value", qk_value, v);
  endtask

  task automatic check_reg();
    chk("rob_commit", 32'(rob_commit), 32'(e_commit));
    chk("rollback", 32'(rollback), 32'(e_rollback));
    if (e_commit) begin
      chk("rob_entry", 32'(rob_entry), 32'(e_entry));
      chk("rob_result", rob_result, e_result);
      chk("commit_rd", 32'(commit_rd), 32'(e_rd));
      chk("commit_store", 32'(commit_store), 32'(e_store));
    end
    if (e_rollback) chk("rollback_pc", rollback_pc, e_rbpc);
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic cycle();
    #1;
    check_comb();
    model_step();
    @(posedge clk);
    #1;
    check_reg();
  endtask

  task automatic idle();
    rst = 0; rdy = 1; issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pred_pc = 0;
    qj_entry = ENTRY_NULL; qk_entry = ENTRY_NULL;
    alu_broadcast = 0; alu_entry = ENTRY_NULL; alu_result = 0; alu_pc_out = 0;
    lsb_broadcast = 0; lsb_entry = ENTRY_NULL; lsb_result = 0;
  endtask

  task automatic set_issue(input int t, input int rd, input logic [31:0] pc);
    issue_valid = 1; issue_type = 2'(t); issue_rd = 5'(rd); issue_pred_pc = pc;
  endtask

  task automatic set_alu(input int e, input logic [31:0] r, input logic [31:0] pc);
    alu_broadcast = 1; alu_entry = 6'(e); alu_result = r; alu_pc_out = pc;
  endtask

  task automatic set_lsb(input int e, input logic [31:0] r);
    lsb_broadcast = 1; lsb_entry = 6'(e); lsb_result = r;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); idle();
  endtask

  // Lookup vector table
  typedef struct {
    logic [5:0]  qj, qk;
    bit          abc;
    logic [5:0]  ae;
    logic [31:0] ar;
    bit          lbc;
    logic [5:0]  le;
    logic [31:0] lr;
    bit          ej_r;
    logic [31:0] ej_v;
    bit          ek_r;
    logic [31:0] ek_v;
  } vec_t;

  vec_t vt [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{6'd4,  6'd2,  1, 6'd4,  32'hBEEF, 0, 6'd32, 32'h0,    1, 32'hBEEF, 1, 32'h2222};
    vt[1] = '{6'd4,  6'd32, 0, 6'd32, 32'h0,    0, 6'd32, 32'h0,    0, 32'h0,    0, 32'h0};
    vt[2] = '{6'd3,  6'd4,  1, 6'd4,  32'hAAAA, 1, 6'd3,  32'h3333, 1, 32'h3333, 1, 32'hAAAA};
    vt[3] = '{6'd5,  6'd10, 1, 6'd5,  32'h5A,   1, 6'd5,  32'h5B,   1, 32'h5A,   0, 32'h0};
    vt[4] = '{6'd10, 6'd2,  1, 6'd10, 32'h77,   1, 6'd2,  32'h9999, 0, 32'h0,    1, 32'h9999};
    vt[5] = '{6'd32, 6'd0,  1, 6'd32, 32'h11,   0, 6'd32, 32'h0,    0, 32'h0,    0, 32'h0};

    // ---- reset state
    idle(); rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst rob_commit", 32'(rob_commit), 32'd0);
    chk("rst rob_entry", 32'(rob_entry), 32'(ENTRY_NULL));
    chk("rst rob_result", rob_result, 32'd0);
    chk("rst commit_rd", 32'(commit_rd), 32'd0);
    chk("rst commit_store", 32'(commit_store), 32'd0);
    chk("rst rollback", 32'(rollback), 32'd0);
    chk("rst rollback_pc", rollback_pc, 32'd0);
    chk("rst rob_full", 32'(rob_full), 32'd0);
    chk("rst issue_entry", 32'(issue_entry), 32'd0);
    idle();

    // ---- single REG issue, writeback, commit two edges later
    set_issue(0, 5, 32'h4);
    #1 chk("t1 issue_entry", 32'(issue_entry), 32'd0);
    cycle(); idle();
    set_alu(0, 32'h1234, 32'h4); cycle(); idle();
    chk("t1 no early commit", 32'(rob_commit), 32'd0);
    cycle();
    chk("t1 commit", 32'(rob_commit), 32'd1);
    chk("t1 entry", 32'(rob_entry), 32'd0);
    chk("t1 result", rob_result, 32'h1234);
    chk("t1 rd", 32'(commit_rd), 32'd5);

    // ---- out-of-order writeback, in-order retire (entries 1..3)
    for (int i = 0; i < 3; i++) begin set_issue(0, 10 + i, 32'h10); cycle(); end
    idle(); set_alu(3, 32'h33, 32'h10); set_lsb(2, 32'h22); cycle();
    idle(); set_alu(1, 32'h11, 32'h10); cycle();
    idle();
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("t2 commit", 32'(rob_commit), 32'd1);
      chk("t2 order", 32'(rob_entry), 32'(i));
      chk("t2 rd", 32'(commit_rd), 32'(9 + i));
    end
    cycle();
    chk("t2 drained", 32'(rob_commit), 32'd0);

    // ---- branch misprediction and rollback (branch lands in entry 4)
    set_issue(1, 7, 32'h100); cycle(); idle();
    set_alu(4, 32'h0, 32'h200); cycle(); idle();
    set_issue(0, 7, 32'h50); cycle();
    chk("t3 commit", 32'(rob_commit), 32'd1);
    chk("t3 rollback", 32'(rollback), 32'd1);
    chk("t3 rollback_pc", rollback_pc, 32'h200);
    chk("t3 branch rd", 32'(commit_rd), 32'd0);
    chk("t3 issue dropped", 32'(issue_entry), 32'd0);
    cycle();
    chk("t3 rollback pulse", 32'(rollback), 32'd0);
    chk("t3 issue during rollback", 32'(issue_entry), 32'd0);
    cycle();
    chk("t3 issue resumes", 32'(issue_entry), 32'd1);
    idle();

    // ---- fill, overflow, wrap
    do_reset();
    for (int i = 0; i < 31; i++) begin set_issue(0, i, 32'h0); cycle(); end
    chk("t4 tail 31", 32'(issue_entry), 32'd31);
    chk("t4 not full", 32'(rob_full), 32'd0);
    cycle();
    chk("t4 wrap", 32'(issue_entry), 32'd0);
    chk("t4 full", 32'(rob_full), 32'd1);
    cycle();
    chk("t4 33rd ignored", 32'(issue_entry), 32'd0);
    chk("t4 still full", 32'(rob_full), 32'd1);
    idle(); set_alu(0, 32'hA0, 32'h0); set_lsb(1, 32'hA1); cycle();
    idle(); set_issue(0, 3, 32'h0); cycle();
    chk("t4 commit0", 32'(rob_entry), 32'd0);
    chk("t4 full blocked issue", 32'(issue_entry), 32'd0);
    cycle();
    chk("t4 commit1", 32'(rob_entry), 32'd1);
    chk("t4 issue+commit", 32'(issue_entry), 32'd1);
    cycle();
    chk("t4 refull", 32'(rob_full), 32'd1);
    idle();

    // ---- combinational lookups (state: entries 0..5 valid, entry 2 ready)
    do_reset();
    for (int i = 0; i < 6; i++) begin set_issue(0, i, 32'h0); cycle(); end
    idle(); set_alu(2, 32'h2222, 32'h0); cycle();
    idle(); rdy = 0;
    foreach (vt[i]) begin
      qj_entry = vt[i].qj; qk_entry = vt[i].qk;
      alu_broadcast = vt[i].abc; alu_entry = vt[i].ae; alu_result = vt[i].ar;
      lsb_broadcast = vt[i].lbc; lsb_entry = vt[i].le; lsb_result = vt[i].lr;
      #1;
      chk($sformatf("vec%0d qj_ready", i), 32'(qj_ready), 32'(vt[i].ej_r));
      chk($sformatf("vec%0d qj_value", i), qj_value, vt[i].ej_v);
      chk($sformatf("vec%0d qk_ready", i), 32'(qk_ready), 32'(vt[i].ek_r));
      chk($sformatf("vec%0d qk_value", i), qk_value, vt[i].ek_v);
    end
    idle(); rdy = 0;
    @(posedge clk); #1;

    // ---- rdy low freezes a ready head; one pulse once released
    idle(); set_alu(0, 32'hAB, 32'h0); cycle();
    idle(); rdy = 0; set_issue(0, 9, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6 frozen commit", 32'(rob_commit), 32'd0);
      chk("t6 frozen issue", 32'(issue_entry), 32'd6);
    end
    idle(); cycle();
    chk("t6 commit", 32'(rob_commit), 32'd1);
    chk("t6 entry", 32'(rob_entry), 32'd0);
    chk("t6 result", rob_result, 32'hAB);
    cycle();
    chk("t6 single pulse", 32'(rob_commit), 32'd0);

    // ---- randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int p;
      logic [31:0] r;
      idle();
      rst = ($urandom_range(0, 999) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_type = 2'($urandom_range(0, 3));
      issue_rd = 5'($urandom);
      r = $urandom;
      issue_pred_pc = r & 32'hFFFF_FFFC;
      alu_broadcast = ($urandom_range(0, 1) == 1);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
        p = $urandom_range(0, mq.size() - 1);
        alu_entry = 6'(mq[p].idx);
        alu_pc_out = ($urandom_range(0, 15) == 0) ? mq[p].pred + 32'd4 : mq[p].pred;
      end else begin
        alu_entry = 6'($urandom_range(0, 32));
        alu_pc_out = $urandom;
      end
      alu_result = $urandom;
      lsb_broadcast = ($urandom_range(0, 3) == 0);
      if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
        p = $urandom_range(0, mq.size() - 1);
        lsb_entry = 6'(mq[p].idx);
      end else begin
        lsb_entry = 6'($urandom_range(0, 32));
      end
      lsb_result = $urandom;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        p = $urandom_range(0, mq.size() - 1);
        qj_entry = 6'(mq[p].idx);
      end else begin
        qj_entry = 6'($urandom_range(0, 32));
      end
      qk_entry = ($urandom_range(0, 1) == 1) ? alu_entry : 6'($urandom_range(0, 32));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
